// File: rtl/snn_cfg_sequencer.sv
// Configuration write-port owner for the neuron network: loads a default image
// after reset or on request, and forwards SPI writes in arrival order through a small queue.
module snn_cfg_sequencer #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int NUM_REGS   = 16,
    parameter int FIFO_DEPTH = 2,
    parameter logic [NUM_REGS*DATA_W-1:0] DEFAULT_IMG = {NUM_REGS*DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_data,
    input  logic              spi_we,
    input  logic              init_start,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] net_addr,
    output logic [DATA_W-1:0] net_data,
    output logic              net_we,
    output logic              busy,
    output logic              init_done,
    output logic              drop_err
);

    localparam int CNT_W  = $clog2(NUM_REGS) + 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(NUM_REGS - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);
    localparam logic [FCNT_W-1:0] FIFO_ONE  = FCNT_W'(1);

    typedef enum logic [1:0] {
        INIT_PEND = 2'd0,
        INIT      = 2'd1,
        DRAIN     = 2'd2,
        IDLE      = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s, nxt_cnt_s;
    logic                pend_r, pend_s;
    logic [ADDR_W-1:0]   net_addr_r, net_addr_s;
    logic [DATA_W-1:0]   net_data_r, net_data_s;
    logic                net_we_r, net_we_s;
    logic                init_done_r, init_done_s;
    logic                drop_err_r, drop_s;
    logic                push_s, pop_s;
    logic                fifo_empty_s, fifo_full_s;
    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
    logic [FCNT_W-1:0]   fcnt_r;
    logic [ADDR_W-1:0]   fifo_addr_r [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data_r [FIFO_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign fifo_empty_s = (fcnt_r == {FCNT_W{1'b0}});
    assign fifo_full_s  = (fcnt_r == FIFO_FULL);
    assign nxt_cnt_s    = cnt_r + CNT_W'(1);
    assign busy         = (state_r != IDLE) || !fifo_empty_s;

    // Next-state, port arbitration and next values of the registered outputs
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        pend_s      = pend_r;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        drop_s      = 1'b0;
        net_we_s    = 1'b0;
        net_addr_s  = net_addr_r;
        net_data_s  = net_data_r;
        init_done_s = init_done_r;
        case (state_r)
            INIT_PEND: begin
                state_s     = INIT;
                cnt_s       = {CNT_W{1'b0}};
                pend_s      = 1'b0;
                init_done_s = 1'b0;
                net_we_s    = 1'b1;
                net_addr_s  = {ADDR_W{1'b0}};
                net_data_s  = DEFAULT_IMG[DATA_W-1:0];
                push_s      = spi_we && !fifo_full_s;
                drop_s      = spi_we && fifo_full_s;
            end
            INIT: begin
                push_s = spi_we && !fifo_full_s;
                drop_s = spi_we && fifo_full_s;
                if (cnt_r == LAST_CNT) begin
                    init_done_s = 1'b1;
                    state_s     = (fifo_empty_s && !push_s) ? IDLE : DRAIN;
                end else begin
                    cnt_s      = nxt_cnt_s;
                    net_we_s   = 1'b1;
                    net_addr_s = ADDR_W'(nxt_cnt_s);
                    net_data_s = DEFAULT_IMG[nxt_cnt_s*DATA_W +: DATA_W];
                end
            end
            DRAIN: begin
                // A pop always happens here, so a push into a full queue is still accepted
                pop_s       = 1'b1;
                push_s      = spi_we;
                net_we_s    = 1'b1;
                net_addr_s  = fifo_addr_r[rd_ptr_r];
                net_data_s  = fifo_data_r[rd_ptr_r];
                pend_s      = pend_r | init_start;
                init_done_s = init_done_r & ~init_start;
                if ((fcnt_r == FIFO_ONE) && !spi_we) begin
                    state_s = pend_s ? INIT_PEND : IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            IDLE: begin
                if (spi_we) begin
                    net_we_s    = 1'b1;
                    net_addr_s  = spi_addr;
                    net_data_s  = spi_data;
                    init_done_s = init_done_r & ~init_start;
                    state_s     = init_start ? INIT_PEND : IDLE;
                end else if (init_start) begin
                    state_s     = INIT;
                    cnt_s       = {CNT_W{1'b0}};
                    init_done_s = 1'b0;
                    net_we_s    = 1'b1;
                    net_addr_s  = {ADDR_W{1'b0}};
                    net_data_s  = DEFAULT_IMG[DATA_W-1:0];
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = INIT_PEND;
            end
        endcase
    end

    // FSM state, load counter and pending-init flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= INIT_PEND;
            cnt_r   <= {CNT_W{1'b0}};
            pend_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            pend_r  <= pend_s;
        end
    end

    // Registered network port and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            net_we_r    <= 1'b0;
            net_addr_r  <= {ADDR_W{1'b0}};
            net_data_r  <= {DATA_W{1'b0}};
            init_done_r <= 1'b0;
            drop_err_r  <= 1'b0;
        end else begin
            net_we_r    <= net_we_s;
            net_addr_r  <= net_addr_s;
            net_data_r  <= net_data_s;
            init_done_r <= init_done_s;
            drop_err_r  <= drop_s ? 1'b1 : (err_clr ? 1'b0 : drop_err_r);
        end
    end

    // SPI queue pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            fcnt_r   <= {FCNT_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({push_s, pop_s})
                2'b10:   fcnt_r <= fcnt_r + FCNT_W'(1);
                2'b01:   fcnt_r <= fcnt_r - FCNT_W'(1);
                default: fcnt_r <= fcnt_r;
            endcase
        end
    end

    // SPI queue storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= spi_addr;
            fifo_data_r[wr_ptr_r] <= spi_data;
        end
    end

    assign net_we    = net_we_r;
    assign net_addr  = net_addr_r;
    assign net_data  = net_data_r;
    assign init_done = init_done_r;
    assign drop_err  = drop_err_r;

endmodule

// File: tb/tb_snn_cfg_sequencer.sv
// Scoreboard bench for snn_cfg_sequencer: stimulus pushes the expected network
// writes in order, a negedge monitor pops and compares every observed write.
module tb_snn_cfg_sequencer;

    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 8;
    localparam int NUM_REGS   = 16;
    localparam int FIFO_DEPTH = 2;

    function automatic logic [NUM_REGS*DATA_W-1:0] mk_img();
        logic [NUM_REGS*DATA_W-1:0] v;
        v = '0;
        for (int a = 0; a < NUM_REGS; a++) v[a*DATA_W +: DATA_W] = DATA_W'(8'h10 + a);
        return v;
    endfunction

    localparam logic [NUM_REGS*DATA_W-1:0] IMG = mk_img();

    logic              clk, reset;
    logic [ADDR_W-1:0] spi_addr, net_addr;
    logic [DATA_W-1:0] spi_data, net_data;
    logic              spi_we, init_start, err_clr;
    logic              net_we, busy, init_done, drop_err;

    snn_cfg_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS),
        .FIFO_DEPTH(FIFO_DEPTH), .DEFAULT_IMG(IMG)
    ) dut (
        .clk(clk), .reset(reset), .spi_addr(spi_addr), .spi_data(spi_data),
        .spi_we(spi_we), .init_start(init_start), .err_clr(err_clr),
        .net_addr(net_addr), .net_data(net_data), .net_we(net_we),
        .busy(busy), .init_done(init_done), .drop_err(drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  done_low_chk = 1'b0;
    bit  drop_exp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every network write must be the next expected one
    always @(negedge clk) begin
        if (reset === 1'b1 && net_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got %0h:%0h expected none", net_addr, net_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("net_write", {20'd0, net_addr, net_data}, {20'd0, e.a, e.d});
                if (done_low_chk) chk("init_done_low", {31'd0, init_done}, 32'd0);
            end
        end
    end

    task automatic push_init();
        logic [NUM_REGS*DATA_W-1:0] img_v;
        wr_t e;
        img_v = IMG;
        for (int a = 0; a < NUM_REGS; a++) begin
            e.a = ADDR_W'(a);
            e.d = img_v[a*DATA_W +: DATA_W];
            exp_q.push_back(e);
        end
    endtask

    // Issue n_spi writes at random cycles while the load runs; the queue holds
    // FIFO_DEPTH of them and the rest are lost.
    task automatic init_window(input int n_spi);
        int  sent = 0;
        int  acc  = 0;
        wr_t e;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            init_start = 1'b0;
            spi_we     = 1'b0;
            if (sent < n_spi && ((14 - c) <= (n_spi - sent) || $urandom_range(0, 2) == 0)) begin
                e.a = ADDR_W'($urandom);
                e.d = DATA_W'($urandom);
                spi_addr = e.a;
                spi_data = e.d;
                spi_we   = 1'b1;
                sent++;
                if (acc < FIFO_DEPTH) begin
                    acc++;
                    exp_q.push_back(e);
                end else begin
                    drop_exp = 1'b1;
                end
            end
        end
        @(negedge clk);
        spi_we = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((busy || exp_q.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_timeout"}, {31'd0, k >= 200}, 32'd0);
        done_low_chk = 1'b0;
    endtask

    task automatic end_checks(input string name);
        chk({name, "_init_done"}, {31'd0, init_done}, 32'd1);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_drop_err"}, {31'd0, drop_err}, {31'd0, drop_exp});
        if (drop_exp) begin
            @(negedge clk);
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            chk({name, "_err_clr"}, {31'd0, drop_err}, 32'd0);
            drop_exp = 1'b0;
        end
    endtask

    task automatic bypass_burst(input int n);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            e.a = ADDR_W'($urandom);
            e.d = DATA_W'($urandom);
            spi_addr = e.a;
            spi_data = e.d;
            spi_we   = 1'b1;
            exp_q.push_back(e);
            @(negedge clk);
            spi_we = 1'b0;
            chk("bypass_we", {31'd0, net_we}, 32'd1);
            chk("bypass_wr", {20'd0, net_addr, net_data}, {20'd0, e.a, e.d});
            @(negedge clk);
            chk("bypass_one_cycle", {31'd0, net_we}, 32'd0);
        end
    endtask

    initial begin
        wr_t e;
        int  k;
        reset = 1'b0; spi_we = 1'b0; init_start = 1'b0; err_clr = 1'b0;
        spi_addr = '0; spi_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_net_we", {31'd0, net_we}, 32'd0);
        chk("rst_net_wr", {20'd0, net_addr, net_data}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_drop_err", {31'd0, drop_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);

        // Power-up load with three SPI writes: two queued, one dropped
        reset = 1'b1;
        push_init();
        init_window(3);
        wait_idle("pwrup");
        end_checks("pwrup");

        bypass_burst(8);

        // Requested reloads, sometimes racing an SPI write
        for (int it = 0; it < 4; it++) begin
            @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                e.a = ADDR_W'($urandom);
                e.d = DATA_W'($urandom);
                spi_addr = e.a; spi_data = e.d; spi_we = 1'b1; init_start = 1'b1;
                exp_q.push_back(e);
                push_init();
                @(negedge clk);
                spi_we = 1'b0; init_start = 1'b0;
            end else begin
                init_start = 1'b1;
                push_init();
            end
            init_window($urandom_range(0, 3));
            wait_idle("reload");
            end_checks("reload");
        end

        // Reload requested while two queued writes drain
        @(negedge clk);
        init_start = 1'b1;
        push_init();
        init_window(2);
        k = 0;
        while (!init_done && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("drain_done_seen", {31'd0, init_done}, 32'd1);
        init_start = 1'b1;
        push_init();
        done_low_chk = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        wait_idle("drain_init");
        end_checks("drain_init");

        // Reset in the middle of a load
        @(negedge clk);
        init_start = 1'b1;
        push_init();
        @(negedge clk);
        init_start = 1'b0;
        k = 0;
        while (exp_q.size() > NUM_REGS - 9 && k < 40) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("midinit_reached", {31'd0, k >= 40}, 32'd0);
        reset = 1'b0;
        #1;
        chk("midinit_net_we", {31'd0, net_we}, 32'd0);
        chk("midinit_init_done", {31'd0, init_done}, 32'd0);
        chk("midinit_busy", {31'd0, busy}, 32'd1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        push_init();
        init_window($urandom_range(0, 3));
        wait_idle("restart");
        end_checks("restart");

        bypass_burst(4);
        repeat (3) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
